// File: rtl/period_to_bpm.sv
// period_to_bpm: bit-serial restoring divider turning a tap period into beats per minute
module period_to_bpm #(
  parameter int PULSE_PER_NS = 5120,
  parameter int PER_WIDTH    = 16,
  parameter int BPM_MAX      = 250,
  parameter int BPM_WIDTH    = $clog2(BPM_MAX + 1),
  parameter bit ROUND        = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [PER_WIDTH-1:0] per_i,
  input  logic                 per_valid_i,
  output logic                 per_ready_o,
  output logic [BPM_WIDTH-1:0] bpm_o,
  output logic                 bpm_valid_o,
  output logic                 sat_o,
  output logic                 err_o
);
  localparam longint DIVIDEND = 64'd60_000_000_000 / PULSE_PER_NS;
  localparam int DW = $clog2(DIVIDEND + 1);
  localparam int CW = $clog2(DW + 1);
  localparam int DP = 1 << CW;
  localparam logic [DP-1:0] DVD = DP'(DIVIDEND);
  localparam logic [1:0] IDLE = 2'd0, COMPUTE = 2'd1, FINISH = 2'd2;
  logic [1:0]           state;
  logic [PER_WIDTH-1:0] div;
  logic [PER_WIDTH:0]   rem, rem_sh;
  logic [DW-1:0]        quo;
  logic [CW-1:0]        cnt, cnt_idx;
  logic [DW:0]          q;
  logic                 err_q, ge, rnd, sat;
  always_comb begin
    cnt_idx = cnt - 1'b1;
    rem_sh  = {rem[PER_WIDTH-1:0], DVD[cnt_idx]};
    ge      = rem_sh >= {1'b0, div};
    // the remainder doubled needs one extra bit to compare against the divisor
    rnd     = ROUND && ({rem, 1'b0} >= {2'b0, div});
    q       = {1'b0, quo} + {{DW{1'b0}}, rnd};
    sat     = q > (DW + 1)'(BPM_MAX);
  end
  assign per_ready_o = state == IDLE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      div         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
      bpm_o       <= '0;
      bpm_valid_o <= 1'b0;
      sat_o       <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      bpm_valid_o <= 1'b0;
      case (state)
        IDLE: if (per_valid_i) begin
          err_q <= per_i == '0;
          div   <= per_i;
          rem   <= '0;
          quo   <= '0;
          cnt   <= CW'(DW);
          state <= per_i == '0 ? FINISH : COMPUTE;
        end
        COMPUTE: begin
          rem   <= ge ? rem_sh - {1'b0, div} : rem_sh;
          quo   <= {quo[DW-2:0], ge};
          cnt   <= cnt_idx;
          state <= cnt == CW'(1) ? FINISH : COMPUTE;
        end
        FINISH: begin
          bpm_valid_o <= 1'b1;
          err_o       <= err_q;
          sat_o       <= !err_q && sat;
          bpm_o       <= err_q ? '0 : sat ? BPM_WIDTH'(BPM_MAX) : q[BPM_WIDTH-1:0];
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_period_to_bpm.sv
// tb_period_to_bpm: scoreboard bench for period_to_bpm, truncating and rounding instances side by side
module tb_period_to_bpm;
  typedef struct packed {logic [7:0] bpm; logic sat; logic err;} res_t;
  logic clk = 1'b0, rst_ni = 1'b0, per_valid_i = 1'b0;
  logic [15:0] per_i = '0;
  logic per_ready_o, bpm_valid_o, sat_o, err_o;
  logic per_ready_r, bpm_valid_r, sat_r, err_r;
  logic [7:0] bpm_o, bpm_r;
  int n_cmp = 0, n_fail = 0;
  res_t exp_q[$], exp_rq[$];
  always #5 clk = ~clk;
  period_to_bpm #(.ROUND(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .per_i(per_i), .per_valid_i(per_valid_i),
    .per_ready_o(per_ready_o), .bpm_o(bpm_o), .bpm_valid_o(bpm_valid_o), .sat_o(sat_o), .err_o(err_o)
  );
  period_to_bpm #(.ROUND(1'b1)) dut_r (
    .clk_i(clk), .rst_ni(rst_ni), .per_i(per_i), .per_valid_i(per_valid_i),
    .per_ready_o(per_ready_r), .bpm_o(bpm_r), .bpm_valid_o(bpm_valid_r), .sat_o(sat_r), .err_o(err_r)
  );
  function automatic res_t model(int unsigned per, bit rnd);
    longint unsigned d = 64'd60_000_000_000 / 5120;
    longint unsigned q, r;
    res_t x;
    if (per == 0) return '{8'd0, 1'b0, 1'b1};
    q = d / per;
    r = d % per;
    if (rnd && 2 * r >= per) q++;
    if (q > 250) x = '{8'd250, 1'b1, 1'b0};
    else x = '{q[7:0], 1'b0, 1'b0};
    return x;
  endfunction
  task automatic issue(input logic [15:0] per);
    per_i = per;
    per_valid_i = 1'b1;
    exp_q.push_back(model(per, 1'b0));
    exp_rq.push_back(model(per, 1'b1));
    @(negedge clk);
    per_valid_i = 1'b0;
    per_i = ~per;
  endtask
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (bpm_valid_o) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    #1;
    n_cmp++;
    if ({bpm_o, bpm_valid_o, sat_o, err_o, per_ready_o} !== 12'b1)
      begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", {bpm_o, bpm_valid_o, sat_o, err_o, per_ready_o}, 12'b1); end
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (per_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", per_ready_o); end
  endtask
  task automatic test_exact();
    int lat;
    res_t e, er;
    issue(16'd46875);
    wait_valid(lat);
    e = exp_q.pop_front();
    er = exp_rq.pop_front();
    n_cmp++;
    if (lat !== 25) begin n_fail++; $display("FAIL exact_latency: got %0d expected 25", lat); end
    n_cmp++;
    if ({bpm_o, sat_o, err_o} !== e) begin n_fail++; $display("FAIL exact_result: got %0d/%b/%b expected %0d/%b/%b", bpm_o, sat_o, err_o, e.bpm, e.sat, e.err); end
    n_cmp++;
    if ({bpm_valid_r, bpm_r, sat_r, err_r} !== {1'b1, er}) begin n_fail++; $display("FAIL exact_round: got %0d expected %0d", bpm_r, er.bpm); end
    @(negedge clk);
    n_cmp++;
    if (bpm_valid_o !== 1'b0) begin n_fail++; $display("FAIL valid_pulse_width: got %b expected 0", bpm_valid_o); end
  endtask
  task automatic test_rounding();
    int lat;
    res_t e, er;
    logic [15:0] pers [2] = '{16'd62500, 16'd65535};
    for (int i = 0; i < 2; i++) begin
      issue(pers[i]);
      wait_valid(lat);
      e = exp_q.pop_front();
      er = exp_rq.pop_front();
      n_cmp++;
      if ({bpm_o, sat_o, err_o} !== e) begin n_fail++; $display("FAIL round_trunc_%0d: got %0d expected %0d", pers[i], bpm_o, e.bpm); end
      n_cmp++;
      if ({bpm_r, sat_r, err_r} !== er) begin n_fail++; $display("FAIL round_near_%0d: got %0d expected %0d", pers[i], bpm_r, er.bpm); end
      @(negedge clk);
    end
  endtask
  task automatic test_saturation();
    int lat;
    res_t e;
    logic [15:0] pers [2] = '{16'd1000, 16'd46875};
    for (int i = 0; i < 2; i++) begin
      issue(pers[i]);
      wait_valid(lat);
      e = exp_q.pop_front();
      void'(exp_rq.pop_front());
      n_cmp++;
      if ({bpm_o, sat_o, err_o} !== e) begin n_fail++; $display("FAIL sat_%0d: got %0d/sat %b expected %0d/sat %b", pers[i], bpm_o, sat_o, e.bpm, e.sat); end
      @(negedge clk);
    end
  endtask
  task automatic test_div_zero();
    int lat;
    res_t e;
    issue(16'd0);
    wait_valid(lat);
    e = exp_q.pop_front();
    void'(exp_rq.pop_front());
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    n_cmp++;
    if ({bpm_o, sat_o, err_o} !== e) begin n_fail++; $display("FAIL zero_result: got %0d/%b/%b expected %0d/%b/%b", bpm_o, sat_o, err_o, e.bpm, e.sat, e.err); end
    n_cmp++;
    if (err_r !== 1'b1) begin n_fail++; $display("FAIL zero_err_round: got %b expected 1", err_r); end
    @(negedge clk);
    issue(16'd62500);
    wait_valid(lat);
    e = exp_q.pop_front();
    void'(exp_rq.pop_front());
    n_cmp++;
    if ({bpm_o, sat_o, err_o} !== e) begin n_fail++; $display("FAIL zero_clear: got %0d/%b/%b expected %0d/%b/%b", bpm_o, sat_o, err_o, e.bpm, e.sat, e.err); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    int got = 0, acc = 0, last = -1;
    res_t e, er;
    for (int c = 0; c < 200 && got < 3; c++) begin
      if (bpm_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++; $display("FAIL b2b_spurious: got valid expected none at cycle %0d", c);
        end else begin
          e = exp_q.pop_front();
          er = exp_rq.pop_front();
          n_cmp++;
          if ({bpm_o, sat_o, err_o} !== e) begin n_fail++; $display("FAIL b2b_result_%0d: got %0d expected %0d", got, bpm_o, e.bpm); end
          n_cmp++;
          if ({bpm_r, sat_r, err_r} !== er) begin n_fail++; $display("FAIL b2b_round_%0d: got %0d expected %0d", got, bpm_r, er.bpm); end
        end
        if (last >= 0) begin
          n_cmp++;
          if (c - last !== 26) begin n_fail++; $display("FAIL b2b_interval: got %0d expected 26", c - last); end
        end
        if (got == 0) begin
          n_cmp++;
          if (per_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_with_valid: got %b expected 1", per_ready_o); end
        end
        last = c;
        got++;
      end
      if (acc < 3) begin
        per_i = 16'($urandom_range(20000, 65535));
        per_valid_i = 1'b1;
        if (per_ready_o) begin
          exp_q.push_back(model(per_i, 1'b0));
          exp_rq.push_back(model(per_i, 1'b1));
          acc++;
        end
      end else per_valid_i = 1'b0;
      @(negedge clk);
    end
    per_valid_i = 1'b0;
    n_cmp++;
    if (got !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", got); end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    issue(16'd46875);
    repeat (9) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({bpm_o, bpm_valid_o, sat_o, err_o, per_ready_o, bpm_r} !== 20'b1_0000_0000)
      begin n_fail++; $display("FAIL mid_reset_outputs: got %0d/%b/%b/%b/%b expected 0/0/0/0/1", bpm_o, bpm_valid_o, sat_o, err_o, per_ready_o); end
    exp_q.delete();
    exp_rq.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bpm_valid_o || bpm_valid_r) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_valid: got %0d pulses expected 0", seen); end
    n_cmp++;
    if (per_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", per_ready_o); end
  endtask
  initial begin
    test_reset();
    test_exact();
    test_rounding();
    test_saturation();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
